// File: rtl/sprite_blitter.sv
// Sprite blitter: maps the beam position onto a ROM-resident, optionally scaled, mirrored
// and animated sprite, producing a palette index two pixel clocks later.
module sprite_blitter #(
  parameter int SPR_W      = 50,
  parameter int SPR_H      = 50,
  parameter int SCALE_SH   = 0,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ANIM_DIV   = 8,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int AW = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             frame_start,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             flip_h,
  input  logic             anim_en,
  input  logic [FW-1:0]    frame_sel,
  output logic [AW-1:0]    rom_addr,
  input  logic [IDX_W-1:0] rom_q,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_opaque,
  output logic [FW-1:0]    cur_frame
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [9:0]       sx_q, sy_q;
  logic             fl_q;
  logic [CW-1:0]    anim_cnt_q, anim_cnt_d;
  logic [FW-1:0]    cur_frame_q, cur_frame_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic             hit_d_q, blank_d_q;
  logic [IDX_W-1:0] pix_idx_q;
  logic             pix_opaque_q;

  logic [10:0] lx, ly, u, v;
  logic        hit;
  logic [31:0] addr_full;

  // Offsets are taken modulo 2^11, so a beam left of/above the sprite yields a huge lx/ly;
  // the explicit >= terms keep that from aliasing into a hit.
  always_comb begin
    lx  = {1'b0, DrawX} - {1'b0, sx_q};
    ly  = {1'b0, DrawY} - {1'b0, sy_q};
    hit = (DrawX >= sx_q) && (DrawY >= sy_q) &&
          ({21'd0, lx} < 32'(SPR_W << SCALE_SH)) &&
          ({21'd0, ly} < 32'(SPR_H << SCALE_SH));
    u = lx >> SCALE_SH;
    v = ly >> SCALE_SH;
    if (fl_q) u = 11'(SPR_W - 1) - u;
    addr_full  = 32'(cur_frame_q) * 32'(SPR_W * SPR_H) + 32'(v) * 32'(SPR_W) + 32'(u);
    rom_addr_d = hit ? AW'(addr_full) : '0;
  end

  always_comb begin
    anim_cnt_d  = anim_cnt_q;
    cur_frame_d = cur_frame_q;
    if (frame_start) begin
      if (anim_en) begin
        if (32'(anim_cnt_q) == 32'(ANIM_DIV - 1)) begin
          anim_cnt_d  = '0;
          cur_frame_d = (32'(cur_frame_q) == 32'(FRAMES - 1)) ? '0 : cur_frame_q + FW'(1);
        end else begin
          anim_cnt_d = anim_cnt_q + CW'(1);
        end
      end else begin
        anim_cnt_d  = '0;
        cur_frame_d = (32'(frame_sel) >= 32'(FRAMES)) ? '0 : frame_sel;
      end
    end
  end

  // NOTE: every stage, pipeline included, is cleared by the async reset so pix_opaque drops the
  // moment reset_n falls; state is written with <= so all stages sample pre-edge values together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q         <= '0;
      sy_q         <= '0;
      fl_q         <= 1'b0;
      anim_cnt_q   <= '0;
      cur_frame_q  <= '0;
      rom_addr_q   <= '0;
      hit_d_q      <= 1'b0;
      blank_d_q    <= 1'b0;
      pix_idx_q    <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      if (frame_start) begin
        sx_q <= pos_x;
        sy_q <= pos_y;
        fl_q <= flip_h;
      end
      anim_cnt_q   <= anim_cnt_d;
      cur_frame_q  <= cur_frame_d;
      rom_addr_q   <= rom_addr_d;
      hit_d_q      <= hit;
      blank_d_q    <= blank;
      pix_idx_q    <= rom_q;
      pix_opaque_q <= hit_d_q && blank_d_q && (32'(rom_q) != 32'(TRANSP_IDX));
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_idx    = pix_idx_q;
  assign pix_opaque = pix_opaque_q;
  assign cur_frame  = cur_frame_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a default instance and a 2x-scaled, 3-frame instance share stimulus
// and are compared against a geometric reference model of sprite placement and animation.
module tb_sprite_blitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic       blank, frame_start, flip_h, anim_en;
  logic [1:0] frame_sel;
  logic [3:0] rom_q;

  logic [13:0] addr0;
  logic [12:0] addr1;
  logic [3:0]  idx0, idx1;
  logic        op0, op1;
  logic [1:0]  fr0, fr1;

  int errors = 0;
  int checks = 0;

  sprite_blitter dut0 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .anim_en(anim_en), .frame_sel(frame_sel), .rom_addr(addr0), .rom_q(rom_q),
    .pix_idx(idx0), .pix_opaque(op0), .cur_frame(fr0)
  );

  sprite_blitter #(.SCALE_SH(1), .FRAMES(3)) dut1 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .anim_en(anim_en), .frame_sel(frame_sel), .rom_addr(addr1), .rom_q(rom_q),
    .pix_idx(idx1), .pix_opaque(op1), .cur_frame(fr1)
  );

  // Reference model state, one entry per instance.
  int m_sx[2], m_sy[2], m_fl[2], m_cnt[2], m_frame[2];

  function automatic int scale_of(int k);  return (k == 0) ? 1 : 2; endfunction
  function automatic int frames_of(int k); return (k == 0) ? 4 : 3; endfunction

  function automatic bit exp_hit(int k, int dx, int dy);
    int s = scale_of(k);
    return dx >= m_sx[k] && dy >= m_sy[k] && (dx - m_sx[k]) < 50 * s && (dy - m_sy[k]) < 50 * s;
  endfunction

  function automatic int exp_addr(int k, int dx, int dy);
    int col, row;
    if (!exp_hit(k, dx, dy)) return 0;
    col = (dx - m_sx[k]) / scale_of(k);
    row = (dy - m_sy[k]) / scale_of(k);
    if (m_fl[k] != 0) col = 49 - col;
    return m_frame[k] * 2500 + row * 50 + col;
  endfunction

  function automatic int obs_addr(int k); return (k == 0) ? int'(addr0) : int'(addr1); endfunction
  function automatic int obs_op(int k);   return (k == 0) ? int'(op0)   : int'(op1);   endfunction
  function automatic int obs_idx(int k);  return (k == 0) ? int'(idx0)  : int'(idx1);  endfunction
  function automatic int obs_fr(int k);   return (k == 0) ? int'(fr0)   : int'(fr1);   endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sx[k] = 0; m_sy[k] = 0; m_fl[k] = 0; m_cnt[k] = 0; m_frame[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fs_e_addr[2], fs_o_addr[2];

  // Frame-start pulse: the address registered on this edge must use the old state.
  task automatic fs_pulse(input int px, input int py, input bit fl, input bit ae, input int sel);
    pos_x = 10'(px); pos_y = 10'(py); flip_h = fl; anim_en = ae; frame_sel = 2'(sel);
    frame_start = 1'b1;
    for (int k = 0; k < 2; k++) fs_e_addr[k] = exp_addr(k, int'(draw_x), int'(draw_y));
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fs_o_addr[k] = obs_addr(k);
      m_sx[k] = px; m_sy[k] = py; m_fl[k] = fl;
      if (ae) begin
        m_cnt[k]++;
        if (m_cnt[k] == 8) begin
          m_cnt[k] = 0;
          m_frame[k] = (m_frame[k] + 1) % frames_of(k);
        end
      end else begin
        m_cnt[k] = 0;
        m_frame[k] = (sel >= frames_of(k)) ? 0 : sel;
      end
    end
  endtask

  int e_addr[2], o_addr[2], e_op[2], o_op[2], o_idx[2];

  // Present one beam position, then the ROM word one clock later; capture both stages.
  task automatic probe(input int dx, input int dy, input bit bl, input int rq);
    bit h[2];
    draw_x = 10'(dx); draw_y = 10'(dy); blank = bl;
    for (int k = 0; k < 2; k++) begin
      e_addr[k] = exp_addr(k, dx, dy);
      h[k] = exp_hit(k, dx, dy);
    end
    tick();
    for (int k = 0; k < 2; k++) o_addr[k] = obs_addr(k);
    rom_q = 4'(rq);
    tick();
    for (int k = 0; k < 2; k++) begin
      o_op[k]  = obs_op(k);
      o_idx[k] = obs_idx(k);
      e_op[k]  = (h[k] && bl && rq != 0) ? 1 : 0;
    end
    blank = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; draw_x = '0; draw_y = '0; pos_x = '0; pos_y = '0; blank = 1'b0;
    frame_start = 1'b0; flip_h = 1'b0; anim_en = 1'b0; frame_sel = '0; rom_q = '0;
    model_reset();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_addr(k) != 0 || obs_op(k) != 0 || obs_idx(k) != 0 || obs_fr(k) != 0) begin
        errors++;
        $display("FAIL reset_state dut%0d: addr=%0d op=%0d idx=%0d frame=%0d, want all 0",
                 k, obs_addr(k), obs_op(k), obs_idx(k), obs_fr(k));
      end
    end
    #3 rst_n = 1'b1;
    probe(5, 1, 1'b1, 9);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_addr[k] != e_addr[k]) begin
        errors++; $display("FAIL reset_origin_addr dut%0d: got %0d want %0d", k, o_addr[k], e_addr[k]);
      end
    end
    checks++;
    if (o_addr[0] != 55) begin
      errors++; $display("FAIL reset_origin_literal: got %0d want 55", o_addr[0]);
    end
  endtask

  task automatic test_basic();
    fs_pulse(100, 50, 1'b0, 1'b0, 0);
    probe(100, 50, 1'b1, 5);
    checks++;
    if (o_addr[0] != 0 || o_op[0] != 1 || o_idx[0] != 5) begin
      errors++;
      $display("FAIL basic_pixel: addr=%0d op=%0d idx=%0d, want 0 1 5", o_addr[0], o_op[0], o_idx[0]);
    end
    probe(149, 99, 1'b1, 3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_addr[k] != e_addr[k] || o_op[k] != e_op[k]) begin
        errors++;
        $display("FAIL basic_corner dut%0d: addr=%0d op=%0d want %0d %0d", k, o_addr[k], o_op[k], e_addr[k], e_op[k]);
      end
    end
  endtask

  task automatic test_scale();
    fs_pulse(0, 0, 1'b0, 1'b0, 0);
    probe(3, 2, 1'b1, 5);
    checks++;
    if (o_addr[1] != 51) begin
      errors++; $display("FAIL scale_addr: got %0d want 51", o_addr[1]);
    end
    probe(100, 2, 1'b1, 5);
    checks++;
    if (o_addr[1] != 0 || o_op[1] != 0) begin
      errors++; $display("FAIL scale_miss: addr=%0d op=%0d want 0 0", o_addr[1], o_op[1]);
    end
    // Right/bottom clipping: no wrap-around to the left edge of the screen.
    fs_pulse(600, 450, 1'b0, 1'b0, 0);
    for (int t = 0; t < 4; t++) begin
      int dx = (t == 0) ? 639 : (t == 1) ? 5 : (t == 2) ? 649 : 600;
      int dy = (t == 3) ? 10 : 479;
      probe(dx, dy, 1'b1, 7);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_addr[k] != e_addr[k] || o_op[k] != e_op[k]) begin
          errors++;
          $display("FAIL clip dut%0d (%0d,%0d): addr=%0d op=%0d want %0d %0d",
                   k, dx, dy, o_addr[k], o_op[k], e_addr[k], e_op[k]);
        end
      end
    end
  endtask

  task automatic test_flip();
    fs_pulse(0, 0, 1'b0, 1'b0, 0);
    draw_x = 10'd5; draw_y = '0; blank = 1'b1;
    fs_pulse(0, 0, 1'b1, 1'b0, 0);
    checks++;
    if (fs_o_addr[0] != 5) begin
      errors++; $display("FAIL coincident_fs: got %0d want 5 (pre-update state)", fs_o_addr[0]);
    end
    probe(0, 0, 1'b1, 4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_addr[k] != 49) begin
        errors++; $display("FAIL flip_addr dut%0d: got %0d want 49", k, o_addr[k]);
      end
    end
    pos_x = 10'd30;
    repeat (3) tick();
    probe(0, 0, 1'b1, 4);
    checks++;
    if (o_addr[0] != 49) begin
      errors++; $display("FAIL midframe_pos: got %0d want 49", o_addr[0]);
    end
    fs_pulse(30, 0, 1'b1, 1'b0, 0);
    probe(30, 0, 1'b1, 4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_addr[k] != e_addr[k]) begin
        errors++; $display("FAIL flip_moved dut%0d: got %0d want %0d", k, o_addr[k], e_addr[k]);
      end
    end
  endtask

  task automatic test_anim();
    fs_pulse(0, 0, 1'b0, 1'b0, 0);
    for (int p = 1; p <= 32; p++) begin
      fs_pulse(0, 0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_fr(k) != m_frame[k]) begin
          errors++; $display("FAIL anim_frame dut%0d pulse %0d: got %0d want %0d", k, p, obs_fr(k), m_frame[k]);
        end
      end
      if (p == 8) begin
        probe(0, 0, 1'b1, 2);
        checks++;
        if (o_addr[0] != 2500) begin
          errors++; $display("FAIL anim_base: got %0d want 2500", o_addr[0]);
        end
      end
    end
    checks++;
    if (fr0 !== 2'd0) begin
      errors++; $display("FAIL anim_wrap: got %0d want 0", fr0);
    end
  endtask

  task automatic test_manual();
    for (int s = 0; s < 4; s++) begin
      fs_pulse(0, 0, 1'b0, 1'b0, 3 - s);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_fr(k) != m_frame[k]) begin
          errors++; $display("FAIL manual_sel dut%0d sel %0d: got %0d want %0d", k, 3 - s, obs_fr(k), m_frame[k]);
        end
      end
    end
    fs_pulse(0, 0, 1'b0, 1'b0, 3);
    checks++;
    if (fr1 !== 2'd0) begin
      errors++; $display("FAIL manual_out_of_range: got %0d want 0", fr1);
    end
    frame_sel = 2'd1; anim_en = 1'b1;
    repeat (4) tick();
    for (int p = 1; p <= 9; p++) begin
      fs_pulse(0, 0, 1'b0, 1'b1, 1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_fr(k) != m_frame[k]) begin
          errors++; $display("FAIL manual_then_anim dut%0d pulse %0d: got %0d want %0d", k, p, obs_fr(k), m_frame[k]);
        end
      end
    end
  endtask

  task automatic test_transp();
    fs_pulse(0, 0, 1'b0, 1'b0, 0);
    for (int t = 0; t < 3; t++) begin
      probe(10, 10, (t != 1), (t == 0) ? 0 : 5);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_op[k] != e_op[k] || o_idx[k] != ((t == 0) ? 0 : 5)) begin
          errors++;
          $display("FAIL transp case %0d dut%0d: op=%0d idx=%0d want op %0d", t, k, o_op[k], o_idx[k], e_op[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ph[2];
    bit pbl;
    fs_pulse(200, 100, 1'($urandom_range(0, 1)), 1'b0, 1);
    draw_x = 10'd197; draw_y = 10'd101; blank = 1'b1; pbl = 1'b1;
    for (int k = 0; k < 2; k++) ph[k] = exp_hit(k, 197, 101);
    tick();
    for (int i = 1; i <= 60; i++) begin
      int dx = 197 + i;
      bit bl = ($urandom_range(0, 7) != 0);
      int rq = $urandom_range(0, 15);
      int ea[2], eo[2];
      for (int k = 0; k < 2; k++) begin
        ea[k] = exp_addr(k, dx, 101);
        eo[k] = (ph[k] && pbl && rq != 0) ? 1 : 0;
      end
      draw_x = 10'(dx); blank = bl; rom_q = 4'(rq);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_addr(k) != ea[k] || obs_op(k) != eo[k] || obs_idx(k) != rq) begin
          errors++;
          $display("FAIL stream dut%0d x=%0d: addr=%0d op=%0d idx=%0d want %0d %0d %0d",
                   k, dx, obs_addr(k), obs_op(k), obs_idx(k), ea[k], eo[k], rq);
        end
        ph[k] = exp_hit(k, dx, 101);
      end
      pbl = bl;
    end
    blank = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int dx, dy;
      if ($urandom_range(0, 7) == 0)
        fs_pulse($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      dx = m_sx[0] + $urandom_range(0, 115) - 5;
      dy = m_sy[0] + $urandom_range(0, 115) - 5;
      if (dx < 0) dx = 0;
      if (dy < 0) dy = 0;
      if (dx > 1023) dx = 1023;
      if (dy > 1023) dy = 1023;
      probe(dx, dy, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_addr[k] != e_addr[k] || o_op[k] != e_op[k]) begin
          errors++;
          $display("FAIL random dut%0d (%0d,%0d): addr=%0d op=%0d want %0d %0d",
                   k, dx, dy, o_addr[k], o_op[k], e_addr[k], e_op[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    fs_pulse(100, 50, 1'b0, 1'b0, 2);
    fs_pulse(100, 50, 1'b0, 1'b0, 2);
    probe(110, 60, 1'b1, 6);
    checks++;
    if (o_op[0] != 1 || fr0 !== 2'd2) begin
      errors++; $display("FAIL reset_mid_setup: op=%0d frame=%0d want 1 2", o_op[0], fr0);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_addr(k) != 0 || obs_op(k) != 0 || obs_idx(k) != 0 || obs_fr(k) != 0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: addr=%0d op=%0d idx=%0d frame=%0d, want all 0",
                 k, obs_addr(k), obs_op(k), obs_idx(k), obs_fr(k));
      end
    end
    model_reset();
    tick();
    #2 rst_n = 1'b1;
    probe(3, 0, 1'b1, 7);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_addr[k] != e_addr[k] || o_op[k] != e_op[k] || obs_fr(k) != 0) begin
        errors++;
        $display("FAIL reset_release dut%0d: addr=%0d op=%0d frame=%0d want %0d %0d 0",
                 k, o_addr[k], o_op[k], obs_fr(k), e_addr[k], e_op[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scale();
    test_flip();
    test_anim();
    test_manual();
    test_transp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
